// File: rtl/lock_ctrl_if.sv
// Keypad handshake bundle: two digit sources (A, B) sharing one entry engine.
interface lock_ctrl_if;
  logic       valid_a;
  logic [7:0] code_a;
  logic       ready_a;
  logic       valid_b;
  logic [7:0] code_b;
  logic       ready_b;

  modport master (output valid_a, code_a, valid_b, code_b,
                  input  ready_a, ready_b);
  modport slave  (input  valid_a, code_a, valid_b, code_b,
                  output ready_a, ready_b);
endinterface

// File: rtl/lock_ctrl.sv
// Combination-lock session controller: round-robin keypad arbitration, three-digit
// check, timed open window, lockout after repeated failures, stalled-session abandon.
module lock_ctrl #(
  parameter logic [7:0]  CODE0          = 8'hAA,
  parameter logic [7:0]  CODE1          = 8'hBB,
  parameter logic [7:0]  CODE2          = 8'hCC,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned IDLE_TIMEOUT   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  lock_ctrl_if.slave  kp,
  input  logic        relock,
  output logic        owner,
  output logic        busy,
  output logic        unlocked,
  output logic        lockout,
  output logic [2:0]  fail_cnt
);

  localparam int unsigned TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned IDL_W   = $clog2(IDLE_TIMEOUT);

  typedef enum logic [2:0] {IDLE, S1, S2, OPEN, LOCK} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [2:0]       fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [IDL_W-1:0] idle_q, idle_d;
  logic             busy_q, unlocked_q, lockout_q;

  logic             ready_a_c, ready_b_c;
  logic             accept_c, sel_b_c, bad_c;
  logic [7:0]       digit_c;

  // Grant: one requester in IDLE (round-robin on contention), only the owner mid-session.
  always_comb begin
    ready_a_c = 1'b0;
    ready_b_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (kp.valid_a && kp.valid_b) begin
          ready_a_c = ~rr_ptr_q;
          ready_b_c = rr_ptr_q;
        end else begin
          ready_a_c = kp.valid_a;
          ready_b_c = kp.valid_b;
        end
      end
      S1, S2: begin
        ready_a_c = kp.valid_a & ~owner_q;
        ready_b_c = kp.valid_b & owner_q;
      end
      default: ;
    endcase
  end

  assign kp.ready_a = ready_a_c;
  assign kp.ready_b = ready_b_c;
  assign sel_b_c    = kp.valid_b & ready_b_c;
  assign accept_c   = (kp.valid_a & ready_a_c) | sel_b_c;
  assign digit_c    = sel_b_c ? kp.code_b : kp.code_a;

  // Next-state: wrong digits flag bad_c and are resolved after the case.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    idle_d     = idle_q;
    bad_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          owner_d = sel_b_c;
          if (digit_c == CODE0) begin
            state_d = S1;
            idle_d  = '0;
          end else begin
            bad_c = 1'b1;
          end
        end
      end
      S1, S2: begin
        if (accept_c) begin
          if (state_q == S1 && digit_c == CODE1) begin
            state_d = S2;
            idle_d  = '0;
          end else if (state_q == S2 && digit_c == CODE2) begin
            state_d    = OPEN;
            fail_cnt_d = '0;
            timer_d    = TMR_W'(OPEN_CYCLES);
          end else begin
            bad_c = 1'b1;
          end
        end else if (idle_q == IDL_W'(IDLE_TIMEOUT - 1)) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end else begin
          idle_d = idle_q + IDL_W'(1);
        end
      end
      OPEN: begin
        if (relock || timer_q <= TMR_W'(1)) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      LOCK: begin
        if (timer_q <= TMR_W'(1)) begin
          state_d    = IDLE;
          fail_cnt_d = '0;
          rr_ptr_d   = ~owner_q;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bad_c) begin
      if (4'(fail_cnt_q) + 4'd1 >= 4'(MAX_TRIES)) begin
        state_d    = LOCK;
        fail_cnt_d = 3'(MAX_TRIES);
        timer_d    = TMR_W'(LOCKOUT_CYCLES);
      end else begin
        state_d    = IDLE;
        fail_cnt_d = fail_cnt_q + 3'd1;
        if (state_q != IDLE) rr_ptr_d = ~owner_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      idle_q     <= '0;
      busy_q     <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      idle_q     <= idle_d;
      busy_q     <= (state_d == S1) || (state_d == S2);
      unlocked_q <= (state_d == OPEN);
      lockout_q  <= (state_d == LOCK);
    end
  end

  assign owner    = owner_q;
  assign busy     = busy_q;
  assign unlocked = unlocked_q;
  assign lockout  = lockout_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Session controller for the three-digit combination lock. It shares one code-entry engine between two keypads (A, B) through round-robin arbitration, and tracks failed attempts with a lockout penalty. It holds the lock open for a fixed window and abandons stalled sessions. It sits between the keypad front-ends and the door actuator / status logic.

## Interface
- CODE0, 8'hAA, first digit of the combination
- CODE1, 8'hBB, second digit
- CODE2, 8'hCC, third digit
- MAX_TRIES, 3, consecutive failed sessions before lockout (1..7)
- OPEN_CYCLES, 8, cycles `unlocked` stays high (>=1)
- LOCKOUT_CYCLES, 16, cycles of lockout (>=1)
- IDLE_TIMEOUT, 32, cycles without an owner digit before a session is abandoned (>=2)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- valid_a  in  1  keypad A presents a digit
- code_a  in  8  keypad A digit
- ready_a  out  1  keypad A digit accepted this cycle when valid_a&&ready_a
- valid_b, code_b, ready_b  same as A, for keypad B
- relock  in  1  force early close while open
- owner  out  1  keypad of the current or last session (0=A, 1=B)
- busy  out  1  a session is in progress (states S1/S2)
- unlocked  out  1  lock open
- lockout  out  1  lockout penalty active
- fail_cnt  out  3  consecutive failed sessions

## Operation
- States: IDLE, S1, S2, OPEN, LOCK.
- Reset values: state=IDLE, owner=0, rr_ptr=0, fail_cnt=0, all timers=0.
  - Outputs after reset: busy=0, unlocked=0, lockout=0.
- ready (combinational, from registered state and the valid inputs):
  - IDLE: ready goes to one requester only.
    - Both valid: rr_ptr wins.
    - One valid: that one wins.
    - None valid: neither.
  - S1/S2: ready = valid of owner only. The other keypad is never ready.
  - OPEN/LOCK: both ready=0.
- A digit is accepted on valid&&ready.
- IDLE, accept:
  - owner<=winner.
  - digit==CODE0 -> S1; else FAIL.
- S1, accept: digit==CODE1 -> S2; else FAIL.
- S2, accept: digit==CODE2 -> OPEN; else FAIL.
- FAIL, applied in the same edge:
  - fail_cnt+1 reaching MAX_TRIES -> LOCK, with the lockout timer loaded to LOCKOUT_CYCLES.
  - Otherwise fail_cnt<=fail_cnt+1 and -> IDLE.
- Entering OPEN:
  - fail_cnt<=0.
  - Open timer loaded to OPEN_CYCLES.
  - Timer reaching 0, or relock=1 -> IDLE.
- LOCK: timer reaching 0 -> IDLE, fail_cnt<=0.
- Session timeout in S1/S2:
  - Idle counter resets on every owner accept.
  - If IDLE_TIMEOUT cycles pass with no accept -> IDLE.
  - A timeout is not a failure: fail_cnt is unchanged.
- Fairness: every transition to IDLE from S1/S2/OPEN/LOCK sets rr_ptr<=~owner.
- Outputs are registered state decodes:
  - busy = S1|S2.
  - unlocked = OPEN.
  - lockout = LOCK.

## Timing
- Accept at cycle N: state and owner update at edge N+1.
- unlocked is high from cycle N+1, where N is the CODE2 accept, for exactly OPEN_CYCLES cycles.
- relock at cycle M in OPEN: unlocked=0 from M+1. relock outside OPEN is ignored.
- lockout is high for exactly LOCKOUT_CYCLES cycles starting the cycle after the failing accept.
- In the IDLE cycle that follows any session end, arbitration already uses the updated rr_ptr.
- Timeout: the last owner accept is at cycle T, and the owner presents no further digit. State is IDLE at cycle T+IDLE_TIMEOUT+1.
- A timeout and an accept in the same cycle: the accept wins.
- fail_cnt saturates by construction: it never exceeds MAX_TRIES-1 outside LOCK.
- reset_n low at any edge: immediate return to the reset values, including mid-session, OPEN and LOCK.

## Test plan
- Only A sends AA,BB,CC back-to-back -> ready_a=1 each cycle. busy for 2 cycles, then unlocked=1 for 8 cycles with owner=0. Then IDLE.
- A sends AA, then B holds valid_b with BB while A sends BB,CC -> ready_b=0 throughout. unlock is credited to owner=0. The next simultaneous request from both is granted to B.
- Three wrong sessions (12,34,56 as first digits) -> fail_cnt counts 1,2, then lockout=1 for 16 cycles with ready_a=ready_b=0. Then fail_cnt=0 and entry works again.
- AA,BB then no input -> IDLE after 32 idle cycles, fail_cnt unchanged. A second session is granted to the other keypad.
- In OPEN, assert relock on the 3rd open cycle -> unlocked=0 next cycle, state IDLE.
- reset_n=0 during S2 and during LOCK -> next cycle all outputs are 0 and fail_cnt=0. A valid A digit is then granted (rr_ptr=0).
